fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 22 ++
 rtl/fetch_unit_if.sv | 14 +
 rtl/fetch_unit_npc_sel.sv | 23 ++
 rtl/fetch_unit.sv | 75 +++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage and the control decoder:
// reset vector, FSM encoding and instruction field positions.
package fetch_unit_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned TARGET_MSB = 25;
    localparam int unsigned TARGET_LSB = 0;

    typedef enum logic {
        FETCH = 1'b0,
        VALID = 1'b1
    } fetch_state_t;

    function automatic logic [5:0] opcode_of(input logic [31:0] word);
        return word[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port: imem_req/imem_addr out, imem_rdata/imem_ready back.
// A read completes in any cycle where imem_req and imem_ready are both 1.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic              imem_req;
    logic [DATA_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic              imem_ready;

    modport master (output imem_req, imem_addr, input imem_rdata, imem_ready);
    modport slave  (input imem_req, imem_addr, output imem_rdata, imem_ready);

endinterface

// File: rtl/fetch_unit_npc_sel.sv
// Combinational next-PC selection: jump beats taken branch beats sequential.
module npc_sel
    import fetch_unit_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [25:0] target,
    input  logic        jump,
    input  logic        branch,
    input  logic        zero,
    input  logic [31:0] imm_ext,
    output logic [31:0] npc
);

    always_comb begin
        npc = pc_plus4;
        if (jump) begin
            npc = {pc_plus4[31:28], target, 2'b00};
        end else if (branch && zero) begin
            npc = pc_plus4 + (imm_ext << 2);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Two-state fetch stage: FETCH requests the word at pc_out, VALID holds it
// until the core commits, then advances the PC and the retired counter.
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    fetch_unit_if.master       imem,
    output logic [31:0]        instr,
    output logic               instr_valid,
    output logic [31:0]        pc_out,
    output logic [31:0]        pc_plus4,
    input  logic               commit,
    input  logic               Jump,
    input  logic               Branch,
    input  logic               Zero,
    input  logic [31:0]        imm_ext,
    output logic [31:0]        retired,
    output fetch_state_t       state
);

    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] retired_q;
    logic [31:0] npc;
    fetch_state_t state_q;

    // Decoder flags are only consumed on a commit, so their value (even X)
    // in any other cycle never reaches a register.
    npc_sel u_npc_sel (
        .pc_plus4 (pc_plus4),
        .target   (instr_q[TARGET_MSB:TARGET_LSB]),
        .jump     (Jump),
        .branch   (Branch),
        .zero     (Zero),
        .imm_ext  (imm_ext),
        .npc      (npc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            retired_q <= '0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (imem.imem_ready) begin
                        instr_q <= imem.imem_rdata;
                        state_q <= VALID;
                    end
                end
                VALID: begin
                    if (commit) begin
                        pc_q      <= npc;
                        retired_q <= retired_q + 32'd1;
                        state_q   <= FETCH;
                    end
                end
                default: state_q <= FETCH;
            endcase
        end
    end

    assign imem.imem_req  = (state_q == FETCH);
    assign imem.imem_addr = pc_q;
    assign instr_valid    = (state_q == VALID);
    assign instr          = instr_q;
    assign pc_out         = pc_q;
    assign pc_plus4       = pc_q + 32'd4;
    assign retired        = retired_q;
    assign state          = state_q;

endmodule
